// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module  : hazard_stall_unit
// Purpose : Load-use / ID-branch hazard stall, HALT drain sequencing and
//           saturating stall/cycle statistics beside the ID stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [4:0]       i_rs_ID,
    input  logic [4:0]       i_rt_ID,
    input  logic             i_uses_rt_ID,
    input  logic             i_branch_ID,
    input  logic             i_halt_ID,
    input  logic [4:0]       i_rd_EX,
    input  logic             i_regwrite_EX,
    input  logic             i_memread_EX,
    input  logic [4:0]       i_rd_MEM,
    input  logic             i_memread_MEM,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_bubble,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic [CNT_W-1:0]       r_stall_cycles;
    logic [CNT_W-1:0]       r_cycle_count;
    logic                   r_halted;

    logic w_dep_ex;
    logic w_dep_mem;
    logic w_hz_lu;
    logic w_hz_bex;
    logic w_hz_bme;
    logic w_hazard;

    // Register 0 is hard-wired to zero, so a write to it never creates a dependency.
    assign w_dep_ex  = (i_rd_EX != 5'd0) &&
                       ((i_rs_ID == i_rd_EX) || (i_uses_rt_ID && (i_rt_ID == i_rd_EX)));
    assign w_dep_mem = (i_rd_MEM != 5'd0) &&
                       ((i_rs_ID == i_rd_MEM) || (i_uses_rt_ID && (i_rt_ID == i_rd_MEM)));

    assign w_hz_lu  = i_memread_EX && w_dep_ex;
    assign w_hz_bex = i_branch_ID && i_regwrite_EX && w_dep_ex;
    assign w_hz_bme = i_branch_ID && i_memread_MEM && w_dep_mem;
    assign w_hazard = w_hz_lu | w_hz_bex | w_hz_bme;

    always_comb begin
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b0;
        if (i_enable) begin
            if (r_state == ST_RUN) begin
                o_pc_write    = ~w_hazard;
                o_ifid_write  = ~w_hazard;
                o_idex_bubble = w_hazard;
            end else begin
                // HALT is parked in IF/ID; keep feeding NOPs so it never re-issues.
                o_idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_RUN;
            r_drain_cnt    <= '0;
            r_stall_cycles <= '0;
            r_cycle_count  <= '0;
            r_halted       <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                ST_RUN: begin
                    if (~&r_cycle_count) r_cycle_count <= r_cycle_count + CNT_W'(1);
                    if (w_hazard) begin
                        if (~&r_stall_cycles) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
                    end else if (i_halt_ID) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= c_DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (~&r_cycle_count) r_cycle_count <= r_cycle_count + CNT_W'(1);
                    if (r_drain_cnt == '0) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - c_DRAIN_W'(1);
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign o_halted       = r_halted;
    assign o_stall_cycles = r_stall_cycles;
    assign o_cycle_count  = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module  : tb_hazard_stall_unit
// Purpose : Vector table, directed corner sequences and random stimulus
//           against a behavioural model of hazard_stall_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

    localparam int DRAIN = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [4:0]    rs, rt, rd_ex, rd_mem;
    logic          uses_rt, branch, halt, regwrite_ex, memread_ex, memread_mem;
    logic          pc_write, ifid_write, bubble, halted;
    logic [CW-1:0] stall_cycles, cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: drain_left counts remaining drain cycles (0 = not draining).
    int m_stall, m_cycle, m_drain_left;
    bit m_halted;

    hazard_stall_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en),
        .i_rs_ID(rs), .i_rt_ID(rt), .i_uses_rt_ID(uses_rt),
        .i_branch_ID(branch), .i_halt_ID(halt),
        .i_rd_EX(rd_ex), .i_regwrite_EX(regwrite_ex), .i_memread_EX(memread_ex),
        .i_rd_MEM(rd_mem), .i_memread_MEM(memread_mem),
        .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_idex_bubble(bubble),
        .o_halted(halted), .o_stall_cycles(stall_cycles), .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, branch;
        logic [4:0] rd_ex;
        logic       regwrite_ex, memread_ex;
        logic [4:0] rd_mem;
        logic       memread_mem;
        logic       exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does the ID instruction read register w (w != 0)?
    function automatic bit id_reads(input logic [4:0] w);
        logic [4:0] srcs[$];
        srcs.push_back(rs);
        if (uses_rt) srcs.push_back(rt);
        if (w == 0) return 1'b0;
        foreach (srcs[i]) if (srcs[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_hazard();
        bit load_in_ex  = memread_ex && id_reads(rd_ex);
        bit alu_to_br   = branch && regwrite_ex && id_reads(rd_ex);
        bit load_to_br  = branch && memread_mem && id_reads(rd_mem);
        return load_in_ex || alu_to_br || load_to_br;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_cycle = 0; m_drain_left = 0; m_halted = 0;
    endtask

    task automatic clear_in();
        en = 1'b1; rs = 0; rt = 0; uses_rt = 0; branch = 0; halt = 0;
        rd_ex = 0; regwrite_ex = 0; memread_ex = 0; rd_mem = 0; memread_mem = 0;
    endtask

    // Compare everything against the model mid-cycle, then advance one clock.
    task automatic tick(input string tag);
        bit running, hz;
        @(negedge clk);
        running = !m_halted && (m_drain_left == 0);
        hz      = model_hazard();
        if (!rst) begin
            chk({tag, ".pc_write"},   {31'd0, pc_write},   {31'd0, en && running && !hz});
            chk({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, en && running && !hz});
            chk({tag, ".bubble"},     {31'd0, bubble},     {31'd0, en && (!running || hz)});
            chk({tag, ".halted"},     {31'd0, halted},     {31'd0, m_halted});
            chk({tag, ".stall_cyc"},  {28'd0, stall_cycles}, m_stall);
            chk({tag, ".cycle_cnt"},  {28'd0, cycle_count},  m_cycle);
        end
        @(posedge clk);
        if (rst) model_reset();
        else if (en) begin
            if (running) begin
                m_cycle = sat_inc(m_cycle);
                if (hz) m_stall = sat_inc(m_stall);
                else if (halt) m_drain_left = DRAIN;
            end else if (m_drain_left > 0) begin
                m_cycle = sat_inc(m_cycle);
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end
        end
        #1;
    endtask

    task automatic expect_out(input string name, input bit p, input bit b, input bit h);
        #1;
        chk({name, ".pc"},     {31'd0, pc_write},   {31'd0, p});
        chk({name, ".ifid"},   {31'd0, ifid_write}, {31'd0, p});
        chk({name, ".bubble"}, {31'd0, bubble},     {31'd0, b});
        chk({name, ".halted"}, {31'd0, halted},     {31'd0, h});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("rst");
        rst = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset and idle
        expect_out("reset", 1, 0, 0);
        chk("reset.stall", {28'd0, stall_cycles}, 0);
        chk("reset.cycle", {28'd0, cycle_count}, 0);
        repeat (10) tick("idle");
        chk("idle.cycle10", {28'd0, cycle_count}, 10);
        chk("idle.stall0",  {28'd0, stall_cycles}, 0);

        // Hazard detection vectors, applied in RUN
        do_reset();
        //              rs rt ut br rdex rw mr rdm mm stall
        vt.push_back('{5, 0, 0, 0, 5, 1, 1, 0, 0, 1});  // load-use on rs
        vt.push_back('{0, 5, 0, 0, 5, 1, 1, 0, 0, 0});  // rt not read
        vt.push_back('{0, 5, 1, 0, 5, 1, 1, 0, 0, 1});  // rt read
        vt.push_back('{0, 0, 1, 0, 0, 1, 1, 0, 0, 0});  // $0 never matches
        vt.push_back('{7, 0, 0, 0, 7, 1, 0, 0, 0, 0});  // ALU result forwarded in EX
        vt.push_back('{7, 0, 0, 1, 7, 1, 0, 0, 0, 1});  // ALU result to branch in ID
        vt.push_back('{0, 9, 1, 1, 0, 0, 0, 9, 1, 1});  // load in MEM to branch
        vt.push_back('{9, 0, 0, 0, 0, 0, 0, 9, 1, 0});  // load in MEM, non-branch
        vt.push_back('{4, 6, 1, 1, 8, 1, 1, 3, 1, 0});  // no register overlap
        foreach (vt[i]) begin
            rs = vt[i].rs; rt = vt[i].rt; uses_rt = vt[i].uses_rt; branch = vt[i].branch;
            rd_ex = vt[i].rd_ex; regwrite_ex = vt[i].regwrite_ex; memread_ex = vt[i].memread_ex;
            rd_mem = vt[i].rd_mem; memread_mem = vt[i].memread_mem;
            expect_out($sformatf("vec%0d", i), !vt[i].exp_stall, vt[i].exp_stall, 0);
            tick($sformatf("vec%0d", i));
        end
        clear_in();

        // Load-use, one stall then release
        do_reset();
        memread_ex = 1; regwrite_ex = 1; rd_ex = 5; rs = 5;
        expect_out("lu.stall", 0, 1, 0);
        tick("lu1");
        memread_ex = 0; regwrite_ex = 0; rd_ex = 0;
        expect_out("lu.free", 1, 0, 0);
        tick("lu2");
        chk("lu.count", {28'd0, stall_cycles}, 1);

        // Load feeding a branch: two stall cycles
        do_reset();
        clear_in();
        branch = 1; rs = 3; memread_ex = 1; regwrite_ex = 1; rd_ex = 3;
        expect_out("lb.c1", 0, 1, 0);
        tick("lb1");
        memread_ex = 0; regwrite_ex = 0; rd_ex = 0; memread_mem = 1; rd_mem = 3;
        expect_out("lb.c2", 0, 1, 0);
        tick("lb2");
        memread_mem = 0; rd_mem = 0;
        expect_out("lb.go", 1, 0, 0);
        tick("lb3");
        chk("lb.count", {28'd0, stall_cycles}, 2);
        clear_in();

        // HALT with a simultaneous hazard, then drain and hold
        do_reset();
        halt = 1; memread_ex = 1; rd_ex = 2; rs = 2;
        expect_out("halt.hz", 0, 1, 0);
        tick("haltHz");
        memread_ex = 0; rd_ex = 0;
        expect_out("halt.run", 1, 0, 0);
        tick("haltRun");
        for (int i = 0; i < DRAIN; i++) begin
            expect_out($sformatf("drain%0d", i), 0, 1, 0);
            tick("drain");
        end
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("halted%0d", i), 0, 1, 1);
            tick("halted");
        end
        do_reset();
        halt = 0;
        expect_out("halt.reset", 1, 0, 0);

        // Reset mid-drain
        halt = 1;
        tick("md0");
        tick("md1");
        halt = 0;
        do_reset();
        expect_out("middrain.run", 1, 0, 0);
        chk("middrain.cycle", {28'd0, cycle_count}, 0);

        // Enable low during hazard; then stall counter saturation
        memread_ex = 1; rd_ex = 6; rs = 6;
        tick("en1");
        en = 0;
        expect_out("en0", 0, 0, 0);
        tick("en0a");
        tick("en0b");
        chk("en0.stall_hold", {28'd0, stall_cycles}, 1);
        en = 1;
        repeat (CMAX - 1) tick("sat");
        chk("sat.full", {28'd0, stall_cycles}, CMAX);
        tick("sat.more");
        chk("sat.hold", {28'd0, stall_cycles}, CMAX);
        chk("sat.cycle", {28'd0, cycle_count}, CMAX);
        clear_in();

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            en          = ($urandom_range(0, 9) != 0);
            rs          = 5'($urandom_range(0, 3));
            rt          = 5'($urandom_range(0, 3));
            rd_ex       = 5'($urandom_range(0, 3));
            rd_mem      = 5'($urandom_range(0, 3));
            uses_rt     = 1'($urandom_range(0, 1));
            branch      = 1'($urandom_range(0, 1));
            regwrite_ex = 1'($urandom_range(0, 1));
            memread_ex  = 1'($urandom_range(0, 2) == 0);
            memread_mem = 1'($urandom_range(0, 2) == 0);
            halt        = ($urandom_range(0, 19) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
